// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences the shared ALU, unified memory port,
// PC/IR updates and register-file write, and selects the immediate format from the IR opcode.
module multicycle_ctrl #(
   parameter bit TRAP_STICKY = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] Instr,
   input  logic        BrCond,
   input  logic        mem_ready,
   output logic        MemReq,
   output logic        MemWe,
   output logic        IorD,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic [1:0]  PCSrc,
   output logic [2:0]  ImmSel,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [3:0]  ALUCtl,
   output logic        RegWrite,
   output logic [1:0]  WBSel,
   output logic        Illegal,
   output logic [2:0]  State
);

   localparam int unsigned OP_W   = 7;
   localparam int unsigned ST_W   = 3;
   localparam int unsigned IMM_W  = 3;
   localparam int unsigned SEL_W  = 2;
   localparam int unsigned CTL_W  = 4;

   localparam logic [OP_W-1:0] OP_LOAD   = 7'h03;
   localparam logic [OP_W-1:0] OP_IMM    = 7'h13;
   localparam logic [OP_W-1:0] OP_AUIPC  = 7'h17;
   localparam logic [OP_W-1:0] OP_STORE  = 7'h23;
   localparam logic [OP_W-1:0] OP_REG    = 7'h33;
   localparam logic [OP_W-1:0] OP_LUI    = 7'h37;
   localparam logic [OP_W-1:0] OP_BRANCH = 7'h63;
   localparam logic [OP_W-1:0] OP_JALR   = 7'h67;
   localparam logic [OP_W-1:0] OP_JAL    = 7'h6F;

   localparam logic [IMM_W-1:0] IMM_I    = 3'd0;
   localparam logic [IMM_W-1:0] IMM_S    = 3'd1;
   localparam logic [IMM_W-1:0] IMM_B    = 3'd2;
   localparam logic [IMM_W-1:0] IMM_J    = 3'd3;
   localparam logic [IMM_W-1:0] IMM_U    = 3'd4;
   localparam logic [IMM_W-1:0] IMM_ZERO = 3'd7;

   localparam logic [SEL_W-1:0] PC_PLUS4  = 2'd0;
   localparam logic [SEL_W-1:0] PC_REL    = 2'd1;
   localparam logic [SEL_W-1:0] PC_ALU    = 2'd2;
   localparam logic [SEL_W-1:0] SRCA_RS1  = 2'd0;
   localparam logic [SEL_W-1:0] SRCA_OPC  = 2'd1;
   localparam logic [SEL_W-1:0] SRCB_RS2  = 2'd0;
   localparam logic [SEL_W-1:0] SRCB_IMM  = 2'd1;
   localparam logic [SEL_W-1:0] WB_ALU    = 2'd0;
   localparam logic [SEL_W-1:0] WB_MEM    = 2'd1;
   localparam logic [SEL_W-1:0] WB_LINK   = 2'd2;
   localparam logic [SEL_W-1:0] WB_IMM    = 2'd3;
   localparam logic [CTL_W-1:0] ALU_ADD   = 4'b0000;

   typedef enum logic [ST_W-1:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [OP_W-1:0]     opcode;
   logic [2:0]          funct3;
   logic                alt;
   logic [IMM_W-1:0]    imm_sel;
   logic                op_legal;
   logic                unused_instr;

   assign opcode       = Instr[6:0];
   assign funct3       = Instr[14:12];
   assign alt          = Instr[30];
   assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

   // Immediate format and legality straight from the opcode; R-type has no immediate.
   always_comb begin
      imm_sel  = IMM_ZERO;
      op_legal = 1'b1;
      case (opcode)
         OP_LOAD, OP_IMM, OP_JALR: imm_sel = IMM_I;
         OP_STORE:                 imm_sel = IMM_S;
         OP_BRANCH:                imm_sel = IMM_B;
         OP_JAL:                   imm_sel = IMM_J;
         OP_LUI, OP_AUIPC:         imm_sel = IMM_U;
         OP_REG:                   imm_sel = IMM_ZERO;
         default:                  op_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_next;
   end

   // Next state and control outputs; everything is forced low while reset is held.
   always_comb begin
      state_next = state;
      MemReq     = 1'b0;
      MemWe      = 1'b0;
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = PC_PLUS4;
      ImmSel     = IMM_ZERO;
      ALUSrcA    = SRCA_RS1;
      ALUSrcB    = SRCB_RS2;
      ALUCtl     = ALU_ADD;
      RegWrite   = 1'b0;
      WBSel      = WB_ALU;
      Illegal    = 1'b0;
      State      = ST_W'(state);

      case (state)
         S_FETCH: begin
            MemReq = 1'b1;
            if (mem_ready) begin
               IRWrite    = 1'b1;
               PCWrite    = 1'b1;
               PCSrc      = PC_PLUS4;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            ImmSel = imm_sel;
            if (op_legal) begin
               state_next = S_EXEC;
            end else begin
               Illegal    = 1'b1;
               state_next = S_TRAP;
            end
         end
         S_EXEC: begin
            ImmSel = imm_sel;
            case (opcode)
               OP_REG: begin
                  ALUCtl     = {alt, funct3};
                  state_next = S_WB;
               end
               OP_IMM: begin
                  // Only the shift-right encoding uses bit 30 as the alternate-op flag.
                  ALUSrcB    = SRCB_IMM;
                  ALUCtl     = {(funct3 == 3'b101) ? alt : 1'b0, funct3};
                  state_next = S_WB;
               end
               OP_LOAD, OP_STORE: begin
                  ALUSrcB    = SRCB_IMM;
                  state_next = S_MEM;
               end
               OP_BRANCH: begin
                  if (BrCond) begin
                     PCWrite = 1'b1;
                     PCSrc   = PC_REL;
                  end
                  state_next = S_FETCH;
               end
               OP_JAL: begin
                  PCWrite    = 1'b1;
                  PCSrc      = PC_REL;
                  state_next = S_WB;
               end
               OP_JALR: begin
                  ALUSrcB    = SRCB_IMM;
                  PCWrite    = 1'b1;
                  PCSrc      = PC_ALU;
                  state_next = S_WB;
               end
               OP_LUI: state_next = S_WB;
               OP_AUIPC: begin
                  ALUSrcA    = SRCA_OPC;
                  ALUSrcB    = SRCB_IMM;
                  state_next = S_WB;
               end
               default: begin
                  Illegal    = 1'b1;
                  state_next = S_TRAP;
               end
            endcase
         end
         S_MEM: begin
            ImmSel = imm_sel;
            MemReq = 1'b1;
            IorD   = 1'b1;
            MemWe  = (opcode == OP_STORE);
            if (mem_ready) state_next = (opcode == OP_STORE) ? S_FETCH : S_WB;
         end
         S_WB: begin
            ImmSel   = imm_sel;
            RegWrite = 1'b1;
            case (opcode)
               OP_LOAD:         WBSel = WB_MEM;
               OP_JAL, OP_JALR: WBSel = WB_LINK;
               OP_LUI:          WBSel = WB_IMM;
               default:         WBSel = WB_ALU;
            endcase
            state_next = S_FETCH;
         end
         S_TRAP: begin
            Illegal = 1'b1;
            if (!TRAP_STICKY) state_next = S_FETCH;
         end
         default: state_next = S_FETCH;
      endcase

      if (!rst_n) begin
         MemReq   = 1'b0;
         MemWe    = 1'b0;
         IorD     = 1'b0;
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         PCSrc    = PC_PLUS4;
         ImmSel   = 3'd0;
         ALUSrcA  = SRCA_RS1;
         ALUSrcB  = SRCB_RS2;
         ALUCtl   = ALU_ADD;
         RegWrite = 1'b0;
         WBSel    = WB_ALU;
         Illegal  = 1'b0;
         State    = 3'd0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl: a transaction model builds a cycle-stamped
// event schedule up front, the driver streams it, and a monitor pops and compares each event.
module tb_multicycle_ctrl;

   localparam int MAXC   = 4096;
   localparam int N_RAND = 150;
   localparam logic [6:0] OPS [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                      7'h6F, 7'h67, 7'h37, 7'h17};

   typedef struct packed {
      logic [31:0] cyc;
      logic [2:0]  st;
      logic        req;
      logic        rdy;
      logic        iord;
      logic        we;
      logic        irw;
      logic        pcw;
      logic [1:0]  pcsrc;
      logic        rw;
      logic [1:0]  wbsel;
      logic [1:0]  a;
      logic [1:0]  b;
      logic [3:0]  ctl;
      logic [2:0]  imm;
      logic        ill;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] Instr;
   logic        BrCond;
   logic        mem_ready;
   logic        MemReq, MemWe, IorD, IRWrite, PCWrite, RegWrite, Illegal;
   logic [1:0]  PCSrc, ALUSrcA, ALUSrcB, WBSel;
   logic [2:0]  ImmSel, State;
   logic [3:0]  ALUCtl;

   multicycle_ctrl #(.TRAP_STICKY(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .Instr(Instr), .BrCond(BrCond), .mem_ready(mem_ready),
      .MemReq(MemReq), .MemWe(MemWe), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .PCSrc(PCSrc), .ImmSel(ImmSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtl(ALUCtl),
      .RegWrite(RegWrite), .WBSel(WBSel), .Illegal(Illegal), .State(State)
   );

   always #5 clk = ~clk;

   ev_t         exp_q [$];
   logic [31:0] instr_at [MAXC];
   logic        br_at    [MAXC];
   logic        rdy_at   [MAXC];
   logic        rstn_at  [MAXC];
   int          cyc;
   int          cur;
   int          end_cyc;
   int          n_vec;
   int          n_err;
   bit          running;
   ev_t         obs;
   ev_t         expv;
   logic [24:0] quiet;

   assign quiet = {MemReq, MemWe, IorD, IRWrite, PCWrite, PCSrc, ImmSel, ALUSrcA, ALUSrcB,
                   ALUCtl, RegWrite, WBSel, Illegal, State};

   function automatic logic [2:0] imm_of(input logic [6:0] op);
      case (op)
         7'h03, 7'h13, 7'h67: return 3'd0;
         7'h23:               return 3'd1;
         7'h63:               return 3'd2;
         7'h6F:               return 3'd3;
         7'h37, 7'h17:        return 3'd4;
         default:             return 3'd7;
      endcase
   endfunction

   function automatic logic legal(input logic [6:0] op);
      return op inside {7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
   endfunction

   function automatic ev_t blank(input int c, input logic [2:0] st, input logic [2:0] imm);
      ev_t e;
      e     = '0;
      e.cyc = 32'(c);
      e.st  = st;
      e.imm = imm;
      return e;
   endfunction

   // First cycle at or after c0 on which memory answers (a long stall is cut short).
   task automatic wait_mem(input int c0, output int cr);
      int c;
      c = c0;
      while (rdy_at[c] !== 1'b1) begin
         if (c - c0 >= 6) rdy_at[c] = 1'b1;
         else             c++;
      end
      cr = c;
   endtask

   // One instruction starting in FETCH at cycle cur; abort_at >= 0 resets after that many MEM waits.
   task automatic run_instr(input logic [31:0] ins, input logic br, input int abort_at,
                            input int trap_len);
      logic [6:0] op;
      logic [2:0] f3;
      logic [2:0] im;
      int         f, e, m, nxt;
      ev_t        ev;
      op = ins[6:0];
      f3 = ins[14:12];
      im = imm_of(op);
      wait_mem(cur, f);
      for (int k = cur; k <= f; k++) begin
         ev     = blank(k, 3'd0, 3'd7);
         ev.req = 1'b1;
         ev.rdy = rdy_at[k];
         ev.irw = (k == f);
         ev.pcw = (k == f);
         exp_q.push_back(ev);
      end
      if (!legal(op)) begin
         ev     = blank(f + 1, 3'd1, 3'd7);
         ev.ill = 1'b1;
         exp_q.push_back(ev);
         for (int k = f + 2; k < f + 2 + trap_len; k++) begin
            ev     = blank(k, 3'd7, 3'd7);
            ev.ill = 1'b1;
            exp_q.push_back(ev);
         end
         nxt = f + 2 + trap_len;
      end else begin
         e  = f + 2;
         ev = blank(e, 3'd2, im);
         case (op)
            7'h33: ev.ctl = {ins[30], f3};
            7'h13: begin ev.b = 2'd1; ev.ctl = {(f3 == 3'd5) ? ins[30] : 1'b0, f3}; end
            7'h03, 7'h23: ev.b = 2'd1;
            7'h63: if (br) begin ev.pcw = 1'b1; ev.pcsrc = 2'd1; end
            7'h6F: begin ev.pcw = 1'b1; ev.pcsrc = 2'd1; end
            7'h67: begin ev.b = 2'd1; ev.pcw = 1'b1; ev.pcsrc = 2'd2; end
            7'h17: begin ev.a = 2'd1; ev.b = 2'd1; end
            default: ;
         endcase
         exp_q.push_back(ev);
         if (op == 7'h63) begin
            nxt = e + 1;
         end else if (op == 7'h03 || op == 7'h23) begin
            if (abort_at >= 0) begin
               for (int k = e + 1; k <= e + 1 + abort_at; k++) rdy_at[k] = 1'b0;
               for (int k = e + 1; k <= e + abort_at; k++) begin
                  ev      = blank(k, 3'd3, im);
                  ev.req  = 1'b1;
                  ev.iord = 1'b1;
                  ev.we   = (op == 7'h23);
                  exp_q.push_back(ev);
               end
               rstn_at[e + 1 + abort_at] = 1'b0;
               rstn_at[e + 2 + abort_at] = 1'b0;
               nxt = e + 3 + abort_at;
            end else begin
               wait_mem(e + 1, m);
               for (int k = e + 1; k <= m; k++) begin
                  ev      = blank(k, 3'd3, im);
                  ev.req  = 1'b1;
                  ev.rdy  = rdy_at[k];
                  ev.iord = 1'b1;
                  ev.we   = (op == 7'h23);
                  exp_q.push_back(ev);
               end
               if (op == 7'h23) begin
                  nxt = m + 1;
               end else begin
                  ev       = blank(m + 1, 3'd4, im);
                  ev.rw    = 1'b1;
                  ev.wbsel = 2'd1;
                  exp_q.push_back(ev);
                  nxt = m + 2;
               end
            end
         end else begin
            ev    = blank(e + 1, 3'd4, im);
            ev.rw = 1'b1;
            if (op == 7'h6F || op == 7'h67) ev.wbsel = 2'd2;
            else if (op == 7'h37)           ev.wbsel = 2'd3;
            exp_q.push_back(ev);
            nxt = e + 2;
         end
      end
      for (int k = cur; k < nxt; k++) begin
         instr_at[k] = ins;
         br_at[k]    = br;
      end
      cur = nxt;
   endtask

   // Zero-wait memory for one instruction, optionally with lw_wait stalls in its MEM phase.
   task automatic directed(input logic [31:0] ins, input logic br, input int lw_wait);
      for (int k = cur; k < cur + 16; k++) rdy_at[k] = 1'b1;
      for (int k = cur + 3; k < cur + 3 + lw_wait; k++) rdy_at[k] = 1'b0;
      run_instr(ins, br, -1, 0);
   endtask

   // Monitor: every cycle that shows a control action is one scoreboard event.
   always @(negedge clk) begin
      if (running) begin
         if (!rst_n) begin
            n_vec++;
            if (quiet !== '0) begin
               n_err++;
               $display("FAIL reset_quiet cyc=%0d outputs=%h required 0", cyc, quiet);
            end
         end else if (MemReq || PCWrite || RegWrite || IRWrite || Illegal || State == 3'd2) begin
            obs       = '0;
            obs.cyc   = 32'(cyc);
            obs.st    = State;
            obs.req   = MemReq;
            obs.rdy   = MemReq & mem_ready;
            obs.iord  = IorD;
            obs.we    = MemWe;
            obs.irw   = IRWrite;
            obs.pcw   = PCWrite;
            obs.pcsrc = PCSrc;
            obs.rw    = RegWrite;
            obs.wbsel = WBSel;
            obs.a     = ALUSrcA;
            obs.b     = ALUSrcB;
            obs.ctl   = ALUCtl;
            obs.imm   = ImmSel;
            obs.ill   = Illegal;
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_event got %h required none", obs);
            end else begin
               expv = exp_q.pop_front();
               if (obs !== expv) begin
                  n_err++;
                  $display("FAIL event cyc=%0d got %h required %h", cyc, obs, expv);
               end
            end
         end
      end
   end

   initial begin
      n_vec   = 0;
      n_err   = 0;
      running = 1'b0;
      for (int k = 0; k < MAXC; k++) begin
         instr_at[k] = 32'h0;
         br_at[k]    = 1'b0;
         rdy_at[k]   = ($urandom_range(0, 3) != 0);
         rstn_at[k]  = 1'b1;
      end
      for (int k = 0; k < 3; k++) rstn_at[k] = 1'b0;
      cur = 3;

      directed(32'h002081B3, 1'b0, 0);   // add x3,x1,x2
      directed(32'h0000A183, 1'b0, 3);   // lw, three MEM wait cycles
      directed(32'h00208063, 1'b1, 0);   // beq taken
      directed(32'h00208063, 1'b0, 0);   // beq not taken
      directed(32'h000080E7, 1'b0, 0);   // jalr

      for (int i = 0; i < N_RAND; i++) begin
         logic [31:0] ins;
         ins      = $urandom;
         ins[6:0] = OPS[$urandom_range(0, 8)];
         run_instr(ins, 1'($urandom_range(0, 1)), -1, 0);
      end

      for (int k = cur; k < cur + 3; k++) rdy_at[k] = 1'b1;
      run_instr(32'h0000A183, 1'b0, 2, 0);      // reset during MEM wait

      rdy_at[cur] = 1'b1;
      run_instr(32'h0000007F, 1'b0, -1, 20);    // illegal opcode, sticky trap
      rstn_at[cur]     = 1'b0;
      rstn_at[cur + 1] = 1'b0;
      cur += 2;
      directed(32'h002081B3, 1'b0, 0);

      for (int k = cur; k < cur + 3; k++) rstn_at[k] = 1'b0;
      end_cyc = cur + 3;

      cyc       = 0;
      rst_n     = rstn_at[0];
      Instr     = instr_at[0];
      BrCond    = br_at[0];
      mem_ready = rdy_at[0];
      running   = 1'b1;
      while (cyc < end_cyc - 1) begin
         @(posedge clk);
         #1;
         cyc++;
         rst_n     = rstn_at[cyc];
         Instr     = instr_at[cyc];
         BrCond    = br_at[cyc];
         mem_ready = rdy_at[cyc];
      end
      @(negedge clk);
      #1;
      running = 1'b0;

      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL queue_drain: %0d events left, required 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
